otter_iobus_timer: RTL
======================

# otter_iobus_timer

Memory-mapped timer/compare peripheral that acts as a responder on the OTTER IOBUS. It decodes `IOBUS_ADDR`, `IOBUS_OUT` and `IOBUS_WR` from the CPU and returns read data on `IOBUS_IN`. It runs a prescaled 32-bit up-counter with a compare match, and raises a level interrupt that feeds the CPU `INTR` input.

## Interface
- `BASE_ADDR`, default 32'h1100_0100: base of the 16-byte register window; bits [3:0] must be 0.
- `CLK` in 1: system clock.
- `RESET` in 1: synchronous, active-high reset.
- `IOBUS_ADDR` in 32: byte address from the CPU.
- `IOBUS_OUT` in 32: write data from the CPU.
- `IOBUS_WR` in 1: write strobe; one cycle per store.
- `IOBUS_IN` out 32: read data to the CPU; combinational from `IOBUS_ADDR` and register state.
- `TMR_INTR` out 1: level interrupt to the CPU `INTR`.

## Operation
- Decode:
  - Hit when `IOBUS_ADDR[31:4] == BASE_ADDR[31:4]`.
  - Offset is `IOBUS_ADDR[3:2]`; `[1:0]` ignored.
  - Writes are full-word only.
  - On a miss, `IOBUS_IN = 0` (responders are OR-combined) and writes are ignored.
- Registers:
  - 0x0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[15:8] PRESCALE; other bits read 0.
  - 0x4 COUNT: read/write.
  - 0x8 COMPARE: read/write.
  - 0xC STATUS: bit0 MATCH_PEND, bit1 OVF. Write-1-to-clear per bit; writing 0 has no effect.
- Prescaler (8-bit `pcnt`):
  - While EN=1, `pcnt` increments each cycle.
  - When `pcnt == PRESCALE`, a tick fires and `pcnt` returns to 0. One tick every PRESCALE+1 cycles.
  - While EN=0, `pcnt` is held at 0 and no ticks fire.
- On a tick:
  - If COUNT == COMPARE: set MATCH_PEND, and COUNT <= (AUTO_RELOAD ? 0 : COUNT+1).
  - Else: COUNT <= COUNT+1.
  - The increment 32'hFFFF_FFFF -> 0 sets OVF.
- `TMR_INTR = MATCH_PEND & IRQ_EN`. The signal is registered state, so no glitch.
- Simultaneous events:
  - A CPU write to COUNT on a tick cycle: the write wins and `pcnt` resets to 0.
  - A W1C clear of MATCH_PEND in the same cycle as a new match: the set wins (bit stays 1).
  - A write to COMPARE on a tick cycle: the match compares against the old COMPARE value.
  - A CTRL write with EN=0 takes effect next cycle; a tick on that write cycle still applies.

## Timing
- Reset values: CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, `pcnt`=0, `TMR_INTR`=0.
- `IOBUS_IN` has zero latency: a combinational mux of the current register values. The CPU memory stage samples it.
- Writes take effect at the `CLK` edge where `IOBUS_WR`=1. A readback in the next cycle returns the new value.
- Start-up: after EN 0→1 is written at edge N, the first tick occurs at edge N+PRESCALE+1.
- Interrupt: a match tick at edge M sets MATCH_PEND at M, and `TMR_INTR` is high from M when IRQ_EN=1.
- `TMR_INTR` falls one edge after a W1C write, unless re-set by a simultaneous match.
- RESET asserted mid-count: all state returns to the reset values at that edge, and bus writes in that cycle are ignored.

## Configuration
- `OTTER_TIMER_ONESHOT_EN` defined:
  - CTRL bit3 ONESHOT is implemented as read/write.
  - On a match tick with ONESHOT=1, EN clears in the same edge and COUNT follows the AUTO_RELOAD rule.
- Not defined:
  - Bit3 reads 0 and writes are ignored.
  - The timer free-runs until software clears EN.

## Test plan
- Reset → read 0x0, 0x4, 0x8, 0xC returns 0, 0, 32'hFFFF_FFFF, 0; `TMR_INTR`=0. Read of an address outside the window returns 0.
- Write COMPARE=5, then CTRL=32'h0000_0307 (PRESCALE=3, EN, AUTO_RELOAD, IRQ_EN) → COUNT steps every 4 cycles. Match fires on the 6th tick, 24 cycles after the enable edge. `TMR_INTR`=1 and COUNT=0 after that edge.
- With `TMR_INTR` high, write STATUS=1 → `TMR_INTR`=0 next cycle. Repeat the W1C on the exact match-tick cycle → MATCH_PEND stays 1.
- Write COUNT=32'hFFFF_FFFE with PRESCALE=0, EN=1, COMPARE=10 → wraps after 2 cycles, OVF=1, MATCH_PEND=0. Write STATUS=2 → OVF=0.
- Write COUNT=100 on a tick cycle → readback is 100, not 101. Next tick lands PRESCALE+1 cycles later.
- Build with `OTTER_TIMER_ONESHOT_EN`, CTRL=32'h9 (EN, ONESHOT), COMPARE=3 → after the match, CTRL bit0=0 and COUNT stays at 4. Without the macro: CTRL reads 32'h1 and counting continues.

Source files
------------

// File: rtl/otter_iobus_timer.sv
// otter_iobus_timer: IOBUS timer/compare responder with prescaler, match/overflow status and level IRQ; define OTTER_TIMER_ONESHOT_EN for CTRL bit3 ONESHOT
module otter_iobus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TMR_INTR
);
  logic        hit, wr_ctrl, wr_count, wr_cmp, wr_stat;
  logic        tick, match, ovf_set;
  logic        en_q, en_d, ar_q, ar_d, ie_q, ie_d, os_q, os_d;
  logic        mp_q, mp_d, ovf_q, ovf_d;
  logic [7:0]  ps_q, ps_d, pcnt_q, pcnt_d;
  logic [31:0] count_q, count_d, cmp_q, cmp_d, ctrl_rd;
  assign hit      = IOBUS_ADDR[31:4] == BASE_ADDR[31:4];
  assign wr_ctrl  = IOBUS_WR && hit && IOBUS_ADDR[3:2] == 2'd0;
  assign wr_count = IOBUS_WR && hit && IOBUS_ADDR[3:2] == 2'd1;
  assign wr_cmp   = IOBUS_WR && hit && IOBUS_ADDR[3:2] == 2'd2;
  assign wr_stat  = IOBUS_WR && hit && IOBUS_ADDR[3:2] == 2'd3;
  assign ctrl_rd  = {16'd0, ps_q, 4'd0, os_q, ie_q, ar_q, en_q};
  assign TMR_INTR = mp_q & ie_q;
  // zero-latency read mux; misses return 0 so responders can be OR-combined
  always_comb begin
    IOBUS_IN = !hit ? 32'd0 :
               IOBUS_ADDR[3:2] == 2'd0 ? ctrl_rd :
               IOBUS_ADDR[3:2] == 2'd1 ? count_q :
               IOBUS_ADDR[3:2] == 2'd2 ? cmp_q : {30'd0, ovf_q, mp_q};
  end
  // prescaler tick, compare match, and next state; bus writes beat counting, match set beats W1C
  always_comb begin
    tick    = en_q && pcnt_q == ps_q;
    match   = tick && count_q == cmp_q;
    ovf_set = tick && !wr_count && !(match && ar_q) && &count_q;
    pcnt_d  = (!en_q || tick || wr_count) ? 8'd0 : pcnt_q + 8'd1;
    count_d = wr_count ? IOBUS_OUT : (match && ar_q) ? 32'd0 : tick ? count_q + 32'd1 : count_q;
    cmp_d   = wr_cmp ? IOBUS_OUT : cmp_q;
    en_d    = wr_ctrl ? IOBUS_OUT[0] : (os_q && match) ? 1'b0 : en_q;
    ar_d    = wr_ctrl ? IOBUS_OUT[1] : ar_q;
    ie_d    = wr_ctrl ? IOBUS_OUT[2] : ie_q;
    ps_d    = wr_ctrl ? IOBUS_OUT[15:8] : ps_q;
`ifdef OTTER_TIMER_ONESHOT_EN
    os_d    = wr_ctrl ? IOBUS_OUT[3] : os_q;
`else
    os_d    = 1'b0;
`endif
    mp_d    = match | (mp_q & ~(wr_stat & IOBUS_OUT[0]));
    ovf_d   = ovf_set | (ovf_q & ~(wr_stat & IOBUS_OUT[1]));
  end
  // state registers; reset wins over any bus write in the same cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      ie_q    <= 1'b0;
      os_q    <= 1'b0;
      ps_q    <= 8'd0;
      pcnt_q  <= 8'd0;
      count_q <= 32'd0;
      cmp_q   <= 32'hFFFF_FFFF;
      mp_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      ar_q    <= ar_d;
      ie_q    <= ie_d;
      os_q    <= os_d;
      ps_q    <= ps_d;
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      mp_q    <= mp_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
